datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Instruction-driven controller for the 8-bit accumulator datapath: operand mux, A/B registers, add/sub ALU.
//  Accepts one micro-instruction at a time over a valid/ready handshake.
//  Drives the mux select, register load strobes and ALU mode.
//  Returns accumulator results over a second valid/ready handshake.
// PARAMETERS
//  W        8   datapath width (imm, alu_result, acc_in, out_data)
//  OPW      3   opcode width
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    synchronous, active-high
//  instr_valid  in   1    instruction offered
//  instr_ready  out  1    sequencer can accept an instruction
//  instr_op     in   OPW  opcode: 0 NOP,1 LDA,2 LDB,3 ADD,4 SUB,5 OUT,6 SKZ,7 reserved
//  instr_imm    in   W    immediate for LDA/LDB
//  imm_out      out  W    immediate to mux input a
//  mux_sel      out  1    1 = immediate, 0 = ALU result
//  load_a       out  1    one-cycle load strobe, register A
//  load_b       out  1    one-cycle load strobe, register B
//  alu_sub      out  1    1 = A-B, 0 = A+B
//  alu_result   in   W    ALU output (combinational from A, B, alu_sub)
//  acc_in       in   W    current register A value
//  out_valid    out  1    result available
//  out_ready    in   1    consumer accepts result
//  out_data     out  W    captured A value
//  busy         out  1    FSM not in IDLE
//  illegal_op   out  1    one-cycle pulse on reserved/disabled opcode
// BEHAVIOUR
//  Reset (sync): FSM=IDLE; all outputs 0 except instr_ready=1; zflag=0, skip=0; latched op/imm cleared.
//  States: IDLE, EXEC, OUTW.
//  IDLE: instr_ready=1. Accept on instr_valid&&instr_ready, latch op/imm, go to EXEC.
//  EXEC lasts exactly 1 cycle, with instr_ready=0. Strobes are decoded from the latched op:
//   LDA: mux_sel=1, load_a=1.  LDB: mux_sel=1, load_b=1.
//   ADD: mux_sel=0, alu_sub=0, load_a=1; zflag<=(alu_result==0).
//   SUB: mux_sel=0, alu_sub=1, load_a=1; zflag<=(alu_result==0).
//   OUT: out_data<=acc_in, go to OUTW.
//   NOP: no strobes.  reserved: illegal_op=1, no strobes.
//   All ops except OUT return to IDLE.
//  OUTW: out_valid=1, out_data stable. On out_ready go to IDLE the same edge; out_valid drops next cycle.
//   No new instruction is accepted while in OUTW.
//  Latency and throughput:
//   Strobes assert the cycle after acceptance.
//   The register updates at the end of that cycle.
//   Peak rate is 1 instruction per 2 cycles.
//  Strobes are never asserted outside EXEC; load_a and load_b are never both high.
//  Arithmetic wraps modulo 2^W in the external ALU. The sequencer does no width extension.
//  Skip: if skip=1 when an instruction is accepted, it is discarded: EXEC with no strobes, no illegal_op.
//   skip clears in that EXEC.
//  Reset mid-operation (EXEC or OUTW): abandon, return to IDLE next edge; no strobe in the reset cycle.
//  instr_valid held while in EXEC/OUTW: not accepted until IDLE. instr_op/imm may change freely while not ready.
// CONFIGURATION
//  SEQ_SKZ_EN defined:
//   SKZ in EXEC sets skip<=zflag; no strobes.
//   zflag is also exported as output port zero_flag (1 bit, reset 0).
//  SEQ_SKZ_EN undefined:
//   opcode 6 is treated as reserved (illegal_op pulse).
//   skip is tied to 0 and no zero_flag port exists.
// STRUCTURE
//  Package seq_pkg: opcode enum (OP_NOP..OP_RSVD), FSM state enum, W default constant.
//  Sub-module seq_decoder: combinational latched-op -> {mux_sel, load_a, load_b, alu_sub, illegal}.
//   Gated by the EXEC state in the parent.
// TESTING
//  1 Reset: assert reset 2 cycles during OUTW -> next cycle IDLE, instr_ready=1, out_valid=0, all strobes 0.
//  2 LDA 0x05, LDB 0x03, ADD, OUT with an external datapath model, out_ready=1:
//    out_data=0x08, out_valid high for 1 cycle; each load strobe is exactly 1 cycle, 1 cycle after its accept.
//  3 LDA 0x02, LDB 0x03, SUB, OUT -> out_data=0xFF (wrap). LDA 0xFF, LDB 0x01, ADD, OUT -> 0x00.
//  4 Backpressure: OUT with out_ready=0 for 5 cycles -> out_valid and out_data stable.
//    instr_ready=0 throughout, even with instr_valid held high; completes the cycle after out_ready=1.
//  5 Opcode 7 -> illegal_op 1-cycle pulse, no strobes, A/B unchanged, back to IDLE next cycle.
//  6 SEQ_SKZ_EN: LDA 3, LDB 3, SUB (zflag=1), SKZ, LDA 0x55, OUT -> out_data=0x00 (LDA skipped).
//    Repeat with SUB result !=0 -> out_data=0x55.
//    Macro off: SKZ pulses illegal_op.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the accumulator datapath sequencer.
// Opcode and FSM encodings plus the decoded strobe bundle.
package seq_pkg;

    localparam int SEQ_W   = 8;
    localparam int SEQ_OPW = 3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDA  = 3'd1,
        OP_LDB  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_OUT  = 3'd5,
        OP_SKZ  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_OUTW = 2'd2
    } state_e;

    typedef struct packed {
        logic mux_sel;
        logic load_a;
        logic load_b;
        logic alu_sub;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction and result handshakes between producer, sequencer and consumer.
// slave = sequencer side, master = environment side.
interface datapath_sequencer_if #(
    parameter int W   = 8,
    parameter int OPW = 3
);
    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] instr_op;
    logic [W-1:0]   instr_imm;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_imm,
        input  out_ready,
        output instr_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output instr_valid,
        output instr_op,
        output instr_imm,
        output out_ready,
        input  instr_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/seq_decoder.sv
// Latched opcode to datapath strobes; the parent gates by EXEC.
// SEQ_SKZ_EN makes opcode 6 a legal, strobe-free SKZ.
module seq_decoder
    import seq_pkg::*;
(
    input  op_e   i_op,
    output ctrl_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (1'b1)
            (i_op == OP_LDA): begin
                o_ctrl.mux_sel = 1'b1;
                o_ctrl.load_a  = 1'b1;
            end
            (i_op == OP_LDB): begin
                o_ctrl.mux_sel = 1'b1;
                o_ctrl.load_b  = 1'b1;
            end
            (i_op == OP_ADD): begin
                o_ctrl.load_a  = 1'b1;
            end
            (i_op == OP_SUB): begin
                o_ctrl.load_a  = 1'b1;
                o_ctrl.alu_sub = 1'b1;
            end
            (i_op == OP_SKZ): begin
`ifdef SEQ_SKZ_EN
                o_ctrl = '0;
`else
                o_ctrl.illegal = 1'b1;
`endif
            end
            (i_op == OP_RSVD): begin
                o_ctrl.illegal = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-instruction sequencer for the 8-bit accumulator datapath.
// Optional SEQ_SKZ_EN adds skip-if-zero and the o_zero_flag port.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int W   = SEQ_W,
    parameter int OPW = SEQ_OPW
) (
    input  logic         clk,
    input  logic         reset,
    datapath_sequencer_if.slave bus,
    output logic [W-1:0] o_imm_out,
    output logic         o_mux_sel,
    output logic         o_load_a,
    output logic         o_load_b,
    output logic         o_alu_sub,
    input  logic [W-1:0] i_alu_result,
    input  logic [W-1:0] i_acc_in,
    output logic         o_busy,
`ifdef SEQ_SKZ_EN
    output logic         o_zero_flag,
`endif
    output logic         o_illegal_op
);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [OPW-1:0] r_op;
    logic [W-1:0]   r_imm;
    logic [W-1:0]   r_out;
    op_e            w_op;
    ctrl_t          w_dec;
    ctrl_t          w_ctrl;
    logic           w_instr_ready;
    logic           w_out_valid;
    logic           w_skip;
    logic           w_exec;

    assign w_op   = op_e'(r_op);
    assign w_exec = (r_state == S_EXEC);

    seq_decoder u_dec (
        .i_op   (w_op),
        .o_ctrl (w_dec)
    );

`ifdef SEQ_SKZ_EN
    logic r_skip;
    logic r_zflag;

    assign w_skip      = r_skip;
    assign o_zero_flag = r_zflag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip  <= 1'b0;
            r_zflag <= 1'b0;
        end else if (w_exec) begin
            if (r_skip) begin
                r_skip <= 1'b0;
            end else begin
                if (w_op == OP_ADD || w_op == OP_SUB)
                    r_zflag <= (i_alu_result == '0);
                if (w_op == OP_SKZ)
                    r_skip <= r_zflag;
            end
        end
    end
`else
    logic w_unused_alu;

    assign w_skip       = 1'b0;
    assign w_unused_alu = ^i_alu_result;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Strobes and out_valid are masked during reset so an abandoned
    // EXEC or OUTW never reaches the datapath or the consumer.
    always_comb begin
        w_state_nxt   = r_state;
        w_ctrl        = '0;
        w_instr_ready = 1'b0;
        w_out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid)
                    w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!w_skip)
                    w_ctrl = w_dec;
                if (!w_skip && w_op == OP_OUT)
                    w_state_nxt = S_OUTW;
                else
                    w_state_nxt = S_IDLE;
            end
            S_OUTW: begin
                w_out_valid = 1'b1;
                if (bus.out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (reset) begin
            w_ctrl      = '0;
            w_out_valid = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= '0;
            r_imm <= '0;
            r_out <= '0;
        end else begin
            if (w_instr_ready && bus.instr_valid) begin
                r_op  <= bus.instr_op;
                r_imm <= bus.instr_imm;
            end
            if (w_exec && !w_skip && w_op == OP_OUT)
                r_out <= i_acc_in;
        end
    end

    assign bus.instr_ready = w_instr_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = r_out;

    assign o_imm_out    = r_imm;
    assign o_mux_sel    = w_ctrl.mux_sel;
    assign o_load_a     = w_ctrl.load_a;
    assign o_load_b     = w_ctrl.load_b;
    assign o_alu_sub    = w_ctrl.alu_sub;
    assign o_illegal_op = w_ctrl.illegal;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with an external A/B/ALU model.
// Define SEQ_SKZ_EN to exercise skip-if-zero.
module tb_datapath_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] imm_out;
    logic       mux_sel, load_a, load_b, alu_sub;
    logic       busy, illegal_op;
    logic [7:0] alu;
    logic [7:0] ra = 8'h00;
    logic [7:0] rb = 8'h00;
`ifdef SEQ_SKZ_EN
    logic       zero_flag;
`endif
    int tests = 0;
    int fails = 0;

    datapath_sequencer_if #(.W(8), .OPW(3)) bus ();

    datapath_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .o_imm_out    (imm_out),
        .o_mux_sel    (mux_sel),
        .o_load_a     (load_a),
        .o_load_b     (load_b),
        .o_alu_sub    (alu_sub),
        .i_alu_result (alu),
        .i_acc_in     (ra),
        .o_busy       (busy),
`ifdef SEQ_SKZ_EN
        .o_zero_flag  (zero_flag),
`endif
        .o_illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign alu = alu_sub ? (ra - rb) : (ra + rb);

    always @(posedge clk) begin
        if (load_a) ra <= mux_sel ? imm_out : alu;
        if (load_b) rb <= mux_sel ? imm_out : alu;
    end

    // Offers one instruction; returns at the EXEC negedge with the strobes seen there.
    task automatic send(input logic [2:0] op, input logic [7:0] imm,
                        output logic [4:0] obs);
        int n;
        n = 0;
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_imm   = imm;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout op=%0d: instr_ready=%b required 1", op, bus.instr_ready);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        obs = {mux_sel, load_a, load_b, alu_sub, illegal_op};
    endtask

    task automatic drain_out(output logic [7:0] d, output int vc);
        d  = 8'h00;
        vc = 0;
        @(negedge clk);
        while (bus.out_valid && vc < 20) begin
            if (vc == 0) d = bus.out_data;
            vc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({bus.instr_ready, bus.out_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_hs: rdy/ov/busy=%b required 100", {bus.instr_ready, bus.out_valid, busy});
        end
        tests++;
        if ({mux_sel, load_a, load_b, alu_sub, illegal_op, bus.out_data, imm_out} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outs: strobes=%b out=%h imm=%h required 0",
                     {mux_sel, load_a, load_b, alu_sub, illegal_op}, bus.out_data, imm_out);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [4:0] obs;
        bus.out_ready = 1'b0;
        send(OP_LDA, 8'h42, obs);
        send(OP_OUT, 8'h00, obs);
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h42) begin
            fails++;
            $display("FAIL outw_entry: ov=%b data=%h required 1 42", bus.out_valid, bus.out_data);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_outw_ov: out_valid=%b required 0", bus.out_valid);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outw_busy: busy=%b required 0", busy);
        end
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({bus.instr_ready, bus.out_valid, load_a, load_b, illegal_op} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outw_after: rdy/ov/la/lb/ill=%b required 10000",
                     {bus.instr_ready, bus.out_valid, load_a, load_b, illegal_op});
        end
        send(OP_LDA, 8'h77, obs);
        reset = 1'b1;
        #1;
        tests++;
        if (load_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_exec_strobe: load_a=%b required 0", load_a);
        end
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (ra !== 8'h42 || bus.instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_exec_after: A=%h rdy=%b required 42 1", ra, bus.instr_ready);
        end
    endtask

    task automatic test_add;
        logic [4:0] obs;
        logic [7:0] d;
        int vc;
        bus.out_ready = 1'b1;
        send(OP_LDA, 8'h05, obs);
        tests++;
        if (obs !== 5'b11000) begin
            fails++;
            $display("FAIL lda_strobe: got %b required 11000", obs);
        end
        @(negedge clk);
        tests++;
        if ({load_a, load_b} !== 2'b00 || ra !== 8'h05) begin
            fails++;
            $display("FAIL lda_width: la/lb=%b A=%h required 00 05", {load_a, load_b}, ra);
        end
        send(OP_LDB, 8'h03, obs);
        tests++;
        if (obs !== 5'b10100) begin
            fails++;
            $display("FAIL ldb_strobe: got %b required 10100", obs);
        end
        @(negedge clk);
        tests++;
        if ({load_a, load_b} !== 2'b00 || rb !== 8'h03) begin
            fails++;
            $display("FAIL ldb_width: la/lb=%b B=%h required 00 03", {load_a, load_b}, rb);
        end
        send(OP_ADD, 8'h00, obs);
        tests++;
        if (obs !== 5'b01000) begin
            fails++;
            $display("FAIL add_strobe: got %b required 01000", obs);
        end
        send(OP_OUT, 8'h00, obs);
        tests++;
        if (obs !== 5'b00000 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL out_exec: strobes=%b ov=%b required 00000 0", obs, bus.out_valid);
        end
        drain_out(d, vc);
        tests++;
        if (d !== 8'h08 || vc !== 1) begin
            fails++;
            $display("FAIL add_out: data=%h valid_cycles=%0d required 08 1", d, vc);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] obs;
        logic [7:0] d;
        int vc;
        bus.out_ready = 1'b1;
        send(OP_LDA, 8'h02, obs);
        send(OP_LDB, 8'h03, obs);
        send(OP_SUB, 8'h00, obs);
        tests++;
        if (obs !== 5'b01010) begin
            fails++;
            $display("FAIL sub_strobe: got %b required 01010", obs);
        end
        send(OP_OUT, 8'h00, obs);
        drain_out(d, vc);
        tests++;
        if (d !== 8'hFF || vc !== 1) begin
            fails++;
            $display("FAIL sub_wrap: data=%h valid_cycles=%0d required ff 1", d, vc);
        end
        send(OP_LDA, 8'hFF, obs);
        send(OP_LDB, 8'h01, obs);
        send(OP_ADD, 8'h00, obs);
        send(OP_OUT, 8'h00, obs);
        drain_out(d, vc);
        tests++;
        if (d !== 8'h00 || vc !== 1) begin
            fails++;
            $display("FAIL add_wrap: data=%h valid_cycles=%0d required 00 1", d, vc);
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] obs;
        bus.out_ready = 1'b0;
        send(OP_LDA, 8'h33, obs);
        send(OP_OUT, 8'h00, obs);
        bus.instr_valid = 1'b1;
        bus.instr_op    = OP_LDB;
        bus.instr_imm   = 8'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.out_valid, bus.instr_ready} !== 2'b10 || bus.out_data !== 8'h33) begin
                fails++;
                $display("FAIL bp_hold[%0d]: ov/rdy=%b data=%h required 10 33",
                         i, {bus.out_valid, bus.instr_ready}, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        tests++;
        if ({bus.out_valid, bus.instr_ready, busy} !== 3'b010 || rb !== 8'h01) begin
            fails++;
            $display("FAIL bp_release: ov/rdy/busy=%b B=%h required 010 01",
                     {bus.out_valid, bus.instr_ready, busy}, rb);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] obs;
        send(OP_LDA, 8'h11, obs);
        send(OP_LDB, 8'h22, obs);
        send(OP_RSVD, 8'hAA, obs);
        tests++;
        if (obs !== 5'b00001) begin
            fails++;
            $display("FAIL rsvd_strobe: got %b required 00001", obs);
        end
        @(negedge clk);
        tests++;
        if ({illegal_op, bus.instr_ready} !== 2'b01 || ra !== 8'h11 || rb !== 8'h22) begin
            fails++;
            $display("FAIL rsvd_after: ill/rdy=%b A=%h B=%h required 01 11 22",
                     {illegal_op, bus.instr_ready}, ra, rb);
        end
    endtask

`ifdef SEQ_SKZ_EN
    task automatic test_skz;
        logic [4:0] obs;
        logic [7:0] d;
        int vc;
        bus.out_ready = 1'b1;
        send(OP_LDA, 8'h03, obs);
        send(OP_LDB, 8'h03, obs);
        send(OP_SUB, 8'h00, obs);
        @(negedge clk);
        tests++;
        if (zero_flag !== 1'b1) begin
            fails++;
            $display("FAIL zflag_set: zero_flag=%b required 1", zero_flag);
        end
        send(OP_SKZ, 8'h00, obs);
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL skz_strobe: got %b required 00000", obs);
        end
        send(OP_LDA, 8'h55, obs);
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL skipped_strobe: got %b required 00000", obs);
        end
        send(OP_OUT, 8'h00, obs);
        drain_out(d, vc);
        tests++;
        if (d !== 8'h00 || vc !== 1) begin
            fails++;
            $display("FAIL skz_taken: data=%h valid_cycles=%0d required 00 1", d, vc);
        end
        send(OP_LDA, 8'h05, obs);
        send(OP_LDB, 8'h03, obs);
        send(OP_SUB, 8'h00, obs);
        @(negedge clk);
        tests++;
        if (zero_flag !== 1'b0) begin
            fails++;
            $display("FAIL zflag_clr: zero_flag=%b required 0", zero_flag);
        end
        send(OP_SKZ, 8'h00, obs);
        send(OP_LDA, 8'h55, obs);
        tests++;
        if (obs !== 5'b11000) begin
            fails++;
            $display("FAIL skz_not_taken_strobe: got %b required 11000", obs);
        end
        send(OP_OUT, 8'h00, obs);
        drain_out(d, vc);
        tests++;
        if (d !== 8'h55 || vc !== 1) begin
            fails++;
            $display("FAIL skz_not_taken: data=%h valid_cycles=%0d required 55 1", d, vc);
        end
    endtask
`else
    task automatic test_skz;
        logic [4:0] obs;
        send(OP_SKZ, 8'h00, obs);
        tests++;
        if (obs !== 5'b00001) begin
            fails++;
            $display("FAIL skz_disabled: got %b required 00001", obs);
        end
        @(negedge clk);
        tests++;
        if ({illegal_op, bus.instr_ready} !== 2'b01) begin
            fails++;
            $display("FAIL skz_disabled_after: ill/rdy=%b required 01", {illegal_op, bus.instr_ready});
        end
    endtask
`endif

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_imm   = 8'h00;
        bus.out_ready   = 1'b0;
        test_reset();
        test_reset_mid_op();
        test_add();
        test_wrap();
        test_backpressure();
        test_illegal();
        test_skz();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
